// File: rtl/frame_dump_seq_pkg.sv
// Shared types and constants for the frame-dump sequencer.
//   state_e   : sequencer states (IDLE, HEADER, FETCH, SEND, NEXT)
//   HDR_*     : frame header sync bytes and header length
//   IDX_BITS  : width of the byte index used for header and word bytes
//   hdr_byte  : selects the header byte for a given index
package frame_dump_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    FETCH,
    SEND,
    NEXT
  } state_e;

  localparam logic [7:0]  HDR_SYNC0 = 8'hA5;
  localparam logic [7:0]  HDR_SYNC1 = 8'h5A;
  localparam int unsigned HDR_LEN   = 4;

  // Covers up to 8 bytes per word and the 4-byte header.
  localparam int unsigned IDX_BITS = 3;

  function automatic logic [7:0] hdr_byte(input logic [IDX_BITS-1:0] idx,
                                          input logic [7:0]          width_b,
                                          input logic [7:0]          height_b);
    logic [7:0] b;
    case (idx)
      IDX_BITS'(0): b = HDR_SYNC0;
      IDX_BITS'(1): b = HDR_SYNC1;
      IDX_BITS'(2): b = width_b;
      default:      b = height_b;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/frame_dump_seq_if.sv
// Frame-buffer read port plus byte-wide UART transmit port.
//   read_x/read_y : buffer address (sequencer -> buffer)
//   read_q        : buffer data, valid one cycle after the address
//   uart_busy_i   : UART transmitting (UART -> sequencer)
//   uart_wr_o     : one-cycle byte strobe (sequencer -> UART)
//   uart_dat_o    : byte, valid with uart_wr_o
// Modports: master = sequencer side, slave = buffer/UART side.
interface frame_dump_seq_if #(
  parameter int unsigned X_BITS = 6,
  parameter int unsigned Y_BITS = 5,
  parameter int unsigned DW     = 32
);
  logic [X_BITS-1:0] read_x;
  logic [Y_BITS-1:0] read_y;
  logic [DW-1:0]     read_q;
  logic              uart_busy_i;
  logic              uart_wr_o;
  logic [7:0]        uart_dat_o;

  modport master (
    output read_x, read_y, uart_wr_o, uart_dat_o,
    input  read_q, uart_busy_i
  );

  modport slave (
    input  read_x, read_y, uart_wr_o, uart_dat_o,
    output read_q, uart_busy_i
  );
endinterface

// File: rtl/frame_dump_debounce.sv
// Trigger synchroniser and release debouncer.
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   trigger_i            : raw asynchronous button
//   press_c              : synced trigger high after a full debounce release
// The counter clears while the button is held and saturates while released,
// so a press only qualifies after 2^DEBOUNCE_BITS-1 released cycles.
module frame_dump_debounce #(
  parameter int unsigned DEBOUNCE_BITS = 14
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  input  logic trigger_i,
  output logic press_c
);

  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

  logic                     trig_s;
  logic [DEBOUNCE_BITS-1:0] cnt_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      trig_s <= 1'b0;
      cnt_q  <= '0;
    end else begin
      trig_s <= trigger_i;
      if (trig_s) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + DEBOUNCE_BITS'(1);
      end
    end
  end

  assign press_c = trig_s && (cnt_q == CNT_MAX);

endmodule

// File: rtl/frame_dump_seq.sv
// Frame-dump sequencer: on a debounced trigger, walks the frame buffer in
// raster order and streams each word MSB byte first into the UART, with a
// holdoff gap after each UART busy period.
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   trigger_i            : raw start button
//   continuous_i         : restart at frame end while high
//   bus                  : buffer read port + UART port (master modport)
//   busy_o               : dump in progress
//   frame_done_o         : one-cycle pulse after the last byte of a frame
// Optional feature: define FRAME_DUMP_HEADER_EN to prefix each frame with
// A5 5A WIDTH_X[7:0] HEIGHT_Y[7:0].
module frame_dump_seq
  import frame_dump_seq_pkg::*;
#(
  parameter int unsigned WIDTH_X        = 40,
  parameter int unsigned HEIGHT_Y       = 30,
  parameter int unsigned X_BITS         = 6,
  parameter int unsigned Y_BITS         = 5,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned HOLDOFF_BITS   = 13,
  parameter int unsigned DEBOUNCE_BITS  = 14
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic            trigger_i,
  input  logic            continuous_i,
  frame_dump_seq_if.master bus,
  output logic            busy_o,
  output logic            frame_done_o
);

  localparam int unsigned DW = 8 * BYTES_PER_WORD;
  localparam logic [HOLDOFF_BITS-1:0] HOLD_MAX = '1;

`ifdef FRAME_DUMP_HEADER_EN
  localparam state_e FIRST_ST = HEADER;
`else
  localparam state_e FIRST_ST = FETCH;
`endif

  state_e                  state_q, state_d;
  logic [X_BITS-1:0]       x_q, x_d;
  logic [Y_BITS-1:0]       y_q, y_d;
  logic [IDX_BITS-1:0]     idx_q, idx_d;
  logic [DW-1:0]           word_q, word_d;
  logic                    fwait_q, fwait_d;
  logic                    wr_q, wr_d;
  logic [7:0]              dat_q, dat_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [HOLDOFF_BITS-1:0] hold_q;
  logic                    press_c;
  logic                    issue_c;

  frame_dump_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debounce (
    .sys_clk_i(sys_clk_i),
    .sys_rst_i(sys_rst_i),
    .trigger_i(trigger_i),
    .press_c  (press_c)
  );

  // A byte may go out only after a full quiet holdoff and never back-to-back.
  assign issue_c = (hold_q == HOLD_MAX) && !bus.uart_busy_i && !wr_q;

  // Holdoff counter: cleared by UART busy, saturates when idle.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      hold_q <= '0;
    end else if (bus.uart_busy_i) begin
      hold_q <= '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_q <= hold_q + HOLDOFF_BITS'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      fwait_q <= 1'b0;
      wr_q    <= 1'b0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      fwait_q <= fwait_d;
      wr_q    <= wr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    word_d  = word_q;
    fwait_d = fwait_q;
    wr_d    = 1'b0;
    dat_d   = dat_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (press_c) begin
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          fwait_d = 1'b0;
          state_d = FIRST_ST;
        end
      end
`ifdef FRAME_DUMP_HEADER_EN
      HEADER: begin
        if (issue_c) begin
          wr_d  = 1'b1;
          dat_d = hdr_byte(idx_q, 8'(WIDTH_X), 8'(HEIGHT_Y));
          if (idx_q == IDX_BITS'(HDR_LEN - 1)) begin
            idx_d   = '0;
            state_d = FETCH;
          end else begin
            idx_d = idx_q + IDX_BITS'(1);
          end
        end
      end
`endif
      // First cycle lets the buffer respond to the new address; second latches it.
      FETCH: begin
        if (fwait_q) begin
          word_d  = bus.read_q;
          fwait_d = 1'b0;
          state_d = SEND;
        end else begin
          fwait_d = 1'b1;
        end
      end
      SEND: begin
        if (issue_c) begin
          wr_d   = 1'b1;
          dat_d  = word_q[DW-1 -: 8];
          word_d = word_q << 8;
          if (idx_q == IDX_BITS'(BYTES_PER_WORD - 1)) begin
            idx_d   = '0;
            state_d = NEXT;
          end else begin
            idx_d = idx_q + IDX_BITS'(1);
          end
        end
      end
      NEXT: begin
        state_d = FETCH;
        if (x_q == X_BITS'(WIDTH_X - 1)) begin
          x_d = '0;
          if (y_q == Y_BITS'(HEIGHT_Y - 1)) begin
            y_d     = '0;
            done_d  = 1'b1;
            state_d = continuous_i ? FIRST_ST : IDLE;
          end else begin
            y_d = y_q + Y_BITS'(1);
          end
        end else begin
          x_d = x_q + X_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.read_x     = x_q;
  assign bus.read_y     = y_q;
  assign bus.uart_wr_o  = wr_q;
  assign bus.uart_dat_o = dat_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = done_q;

endmodule

// File: tb/tb_frame_dump_seq.sv
// Directed bench for frame_dump_seq with small geometry (4x2 words, 2 bytes
// per word, 3-bit holdoff and debounce). Buffer model returns
// {row nibble, col nibble, 8'h00}; UART model is busy 5 cycles per strobe.
module tb_frame_dump_seq;
  import frame_dump_seq_pkg::*;

  localparam int unsigned WX  = 4;
  localparam int unsigned HY  = 2;
  localparam int unsigned XB  = 2;
  localparam int unsigned YB  = 1;
  localparam int unsigned BPW = 2;
  localparam int unsigned DW  = 16;
  localparam int unsigned HB  = 3;
  localparam int unsigned DB  = 3;
`ifdef FRAME_DUMP_HEADER_EN
  localparam int NHDR = 4;
`else
  localparam int NHDR = 0;
`endif
  localparam int NBYTES = NHDR + 16;

  logic sys_clk_i = 1'b0;
  logic sys_rst_i;
  logic trigger_i;
  logic continuous_i;
  logic busy_o;
  logic frame_done_o;

  frame_dump_seq_if #(.X_BITS(XB), .Y_BITS(YB), .DW(DW)) bus ();

  frame_dump_seq #(
    .WIDTH_X(WX), .HEIGHT_Y(HY), .X_BITS(XB), .Y_BITS(YB),
    .BYTES_PER_WORD(BPW), .HOLDOFF_BITS(HB), .DEBOUNCE_BITS(DB)
  ) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_i   (sys_rst_i),
    .trigger_i   (trigger_i),
    .continuous_i(continuous_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  // Synchronous buffer model and UART busy model.
  int ubusy_cnt = 0;
  always @(posedge sys_clk_i) begin
    bus.read_q <= {4'(bus.read_y), 4'(bus.read_x), 8'h00};
    if (bus.uart_wr_o) ubusy_cnt <= 5;
    else if (ubusy_cnt != 0) ubusy_cnt <= ubusy_cnt - 1;
  end
  assign bus.uart_busy_i = (ubusy_cnt != 0);

  // Monitor: captures bytes, frame_done pulses, spacing violations.
  int         cyc = 0;
  logic [7:0] cap[$];
  int         done_at[$];
  int         n_done = 0;
  int         b2b_viol = 0;
  int         min_gap = 1000;
  int         fall_cyc = 0;
  logic       fall_seen = 1'b0;
  logic       prev_wr = 1'b0;
  logic       prev_busy = 1'b0;

  always @(posedge sys_clk_i) begin
    #1;
    cyc++;
    if (bus.uart_wr_o === 1'b1) begin
      cap.push_back(bus.uart_dat_o);
      if (prev_wr) b2b_viol++;
      if (fall_seen && (cyc - fall_cyc) < min_gap) min_gap = cyc - fall_cyc;
      fall_seen = 1'b0;
    end
    if (prev_busy && !bus.uart_busy_i) begin
      fall_cyc  = cyc;
      fall_seen = 1'b1;
    end
    if (frame_done_o === 1'b1) begin
      n_done++;
      done_at.push_back(cap.size());
    end
    prev_wr   = (bus.uart_wr_o === 1'b1);
    prev_busy = bus.uart_busy_i;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [NBYTES];

  task automatic compare_frame(input string tag, input int base);
    int act;
    for (int i = 0; i < NBYTES; i++) begin
      act = (base + tbl[i].idx < cap.size()) ? int'(cap[base + tbl[i].idx]) : -1;
      check($sformatf("%s_byte%0d", tag, tbl[i].idx), act, tbl[i].exp);
    end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy_o && n < bound) begin
      @(negedge sys_clk_i);
      n++;
    end
    check({name, "_idle_in_time"}, busy_o, 0);
  endtask

  task automatic wait_strobes(input string name, input int target, input int bound);
    int n = 0;
    while (cap.size() < target && n < bound) begin
      @(negedge sys_clk_i);
      n++;
    end
    check({name, "_strobes_in_time"}, cap.size() >= target, 1);
  endtask

  task automatic press(input int cycles);
    trigger_i = 1'b1;
    repeat (cycles) @(negedge sys_clk_i);
    trigger_i = 1'b0;
  endtask

  task automatic clear_capture();
    cap.delete();
    done_at.delete();
    n_done = 0;
  endtask

  initial begin
    logic [7:0] data_exp [16];
`ifdef FRAME_DUMP_HEADER_EN
    logic [7:0] hdr_exp [4];
    hdr_exp = '{8'hA5, 8'h5A, 8'h04, 8'h02};
    for (int i = 0; i < NHDR; i++) tbl[i] = '{i, hdr_exp[i]};
`endif
    data_exp = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00,
                 8'h10, 8'h00, 8'h11, 8'h00, 8'h12, 8'h00, 8'h13, 8'h00};
    for (int i = 0; i < 16; i++) tbl[NHDR + i] = '{NHDR + i, data_exp[i]};

    sys_rst_i    = 1'b1;
    trigger_i    = 1'b0;
    continuous_i = 1'b0;
    repeat (3) @(negedge sys_clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_wr", bus.uart_wr_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_read_x", bus.read_x, 0);
    check("rst_read_y", bus.read_y, 0);
    check("rst_dat", bus.uart_dat_o, 0);
    sys_rst_i = 1'b0;

    // Only 3 released cycles since reset: press must not start.
    repeat (3) @(negedge sys_clk_i);
    press(4);
    repeat (4) @(negedge sys_clk_i);
    check("short_release_busy", busy_o, 0);
    check("short_release_strobes", cap.size(), 0);

    // Single dump; a second press mid-dump is ignored.
    repeat (12) @(negedge sys_clk_i);
    clear_capture();
    trigger_i = 1'b1;
    @(negedge sys_clk_i);
    check("trig_lat_1", busy_o, 0);
    @(negedge sys_clk_i);
    check("trig_lat_2", busy_o, 1);
    repeat (2) @(negedge sys_clk_i);
    trigger_i = 1'b0;
    wait_strobes("mid_press", 6, 1000);
    press(3);
    wait_idle("dump1", 3000);
    repeat (30) @(negedge sys_clk_i);
    check("dump1_count", cap.size(), NBYTES);
    compare_frame("dump1", 0);
    check("dump1_done_pulses", n_done, 1);
    check("dump1_done_after_last", (done_at.size() > 0) ? done_at[0] : -1, NBYTES);
    check("dump1_busy_end", busy_o, 0);

    // Continuous: two back-to-back frames, dropping continuous after the first.
    clear_capture();
    continuous_i = 1'b1;
    press(2);
    begin
      int n = 0;
      while (!frame_done_o && n < 3000) begin
        @(negedge sys_clk_i);
        n++;
      end
    end
    check("cont_done_seen", frame_done_o, 1);
    check("cont_busy_at_done", busy_o, 1);
    continuous_i = 1'b0;
    wait_idle("cont", 3000);
    repeat (30) @(negedge sys_clk_i);
    check("cont_count", cap.size(), 2 * NBYTES);
    check("cont_done_pulses", n_done, 2);
    check("cont_done0_at", (done_at.size() > 0) ? done_at[0] : -1, NBYTES);
    check("cont_done1_at", (done_at.size() > 1) ? done_at[1] : -1, 2 * NBYTES);
    compare_frame("cont_f0", 0);
    compare_frame("cont_f1", NBYTES);

    // Reset mid-dump after the fifth byte, then restart from byte 0.
    clear_capture();
    press(2);
    wait_strobes("rstmid", 5, 1000);
    sys_rst_i = 1'b1;
    @(negedge sys_clk_i);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_wr", bus.uart_wr_o, 0);
    check("rstmid_read_x", bus.read_x, 0);
    check("rstmid_read_y", bus.read_y, 0);
    check("rstmid_done", frame_done_o, 0);
    sys_rst_i = 1'b0;
    repeat (12) @(negedge sys_clk_i);
    check("rstmid_no_more_strobes", cap.size(), 5);
    clear_capture();
    press(2);
    @(negedge sys_clk_i);
    wait_idle("restart", 3000);
    repeat (30) @(negedge sys_clk_i);
    check("restart_count", cap.size(), NBYTES);
    compare_frame("restart", 0);

    check("no_back_to_back", b2b_viol, 0);
    check("holdoff_gap_ge7", min_gap >= 7, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_dump_seq.md
# frame_dump_seq

Parametrised frame-dump sequencer for the icebreaker CSI-2 test design. On a debounced trigger, it walks every word of a downsampled frame buffer in raster order and streams each word, MSB byte first, into the byte-wide UART transmitter. It enforces a post-busy holdoff between bytes and can optionally prefix each frame with a sync/geometry header. Continuous mode re-dumps back-to-back frames without a new trigger. It sits between the downsample read port and the UART, all in the system clock domain.

## Interface
- WIDTH_X, 40, words per row (1..255)
- HEIGHT_Y, 30, rows per frame (1..255)
- X_BITS, 6, read_x width; 2^X_BITS ≥ WIDTH_X
- Y_BITS, 5, read_y width; 2^Y_BITS ≥ HEIGHT_Y
- BYTES_PER_WORD, 4, bytes per buffer word (1..8); word width DW = 8*BYTES_PER_WORD
- HOLDOFF_BITS, 13, holdoff counter width; gap = 2^HOLDOFF_BITS-1 cycles
- DEBOUNCE_BITS, 14, trigger debounce counter width

- sys_clk_i  in  1  system clock (12 MHz)
- sys_rst_i  in  1  reset, synchronous, active-high
- trigger_i  in  1  raw button, asynchronous, active-high
- continuous_i  in  1  level; restart at frame end while high
- read_x  out  X_BITS  buffer column address
- read_y  out  Y_BITS  buffer row address
- read_q  in  DW  buffer data, valid 1 cycle after address
- uart_busy_i  in  1  UART transmitting
- uart_wr_o  out  1  one-cycle byte strobe
- uart_dat_o  out  8  byte, valid with uart_wr_o
- busy_o  out  1  dump in progress
- frame_done_o  out  1  one-cycle pulse after last byte of a frame

## Operation
- Reset: all outputs 0; state IDLE; counters 0; trigger sync/debounce cleared (not armed).
- Trigger: one sync flop. Debounce counter clears while synced trigger is high and counts up to saturation while low. Start occurs when synced trigger is high, the counter is saturated, and state is IDLE. Release must last 2^DEBOUNCE_BITS-1 cycles before the next start.
- Holdoff: counter clears while uart_busy_i is high, otherwise increments to saturation. Byte issue requires saturated holdoff, !uart_busy_i, and uart_wr_o low in the previous cycle.
- States:
  - IDLE → (start) HEADER if enabled, else FETCH; read_x/read_y/byte index = 0.
  - HEADER: send the header bytes → FETCH.
  - FETCH: wait 1 cycle, then latch read_q into the word register → SEND.
  - SEND: issue bytes [DW-1:DW-8] first; after BYTES_PER_WORD bytes → NEXT.
  - NEXT: read_x++; at WIDTH_X-1, read_x = 0 and read_y++. After the last word, pulse frame_done_o and go to HEADER/FETCH if continuous_i is high, otherwise IDLE. Otherwise → FETCH.
- busy_o is high in every state except IDLE.
- Triggers while busy are ignored (not queued).
- Address counters wrap only via explicit compare, never by natural overflow.
- sys_rst_i mid-dump: return to IDLE next edge. No partial byte strobe.

## Timing
- uart_dat_o is registered, stable from the strobe cycle until the next strobe.
- Trigger (stable high, armed) to busy_o: 2 cycles after trigger_i rises.
- First byte strobe occurs no earlier than FETCH+1 and only after the holdoff condition is met.
- Minimum byte spacing: strobe, then busy high, then 2^HOLDOFF_BITS-1 idle cycles after busy falls.
- frame_done_o is asserted the cycle after the final strobe's NEXT transition.

## Configuration
- FRAME_DUMP_HEADER_EN defined: before each frame, send 0xA5, 0x5A, WIDTH_X[7:0], HEIGHT_Y[7:0] under the same holdoff rules.
- FRAME_DUMP_HEADER_EN not defined: the HEADER state and its logic are absent; the frame starts directly in FETCH.

## Structure
- Shared package: the state enum (IDLE, HEADER, FETCH, SEND, NEXT), the header byte constants 0xA5/0x5A, and the header length (4).
- One sub-module: frame_dump_debounce (sync flop + saturating counter + start pulse), parametrised by DEBOUNCE_BITS.

## Test plan
Use small parameters: WIDTH_X=4, HEIGHT_Y=2, BYTES_PER_WORD=2, HOLDOFF_BITS=3, DEBOUNCE_BITS=3. The UART model holds busy for 5 cycles after each strobe. read_q = {row, col, 8'h00…}.
- Single dump, header off: trigger after 7 low cycles → exactly 16 strobes, bytes {y,x} pairs 0x00,0x00 … 0x13,0x00 in raster order; one frame_done_o pulse; busy_o drops.
- Header on: same trigger → first 4 bytes 0xA5, 0x5A, 0x04, 0x02, then 16 data bytes.
- Debounce: trigger after only 3 low cycles → no start; trigger pressed during a dump → ignored, total strobes remain 16.
- Holdoff: measure gaps → ≥7 cycles between busy falling and the next strobe; never two strobes in consecutive cycles.
- Continuous: continuous_i held high → frame_done_o every 16 bytes, with the next byte read from (0,0); drop continuous_i → stop after the current frame.
- Reset mid-dump: assert sys_rst_i after byte 5 → next edge busy_o=0, uart_wr_o=0, addresses 0; a new trigger restarts from byte 0.
